// File: rtl/btn_ctrl_pkg.sv
// Shared definitions for the multi-channel button controller:
// per-channel FSM state encoding and default timing constants.
package btn_ctrl_pkg;

  localparam int unsigned DEF_N_BTN    = 4;
  localparam int unsigned DEF_CNT_W    = 25;
  localparam int unsigned DEF_DEBOUNCE = 2500;
  localparam int unsigned DEF_DELAY    = 5000000;
  localparam int unsigned DEF_REPEAT   = 1250000;

  // S_ prefix keeps the state names distinct from the timing parameters.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_DELAY    = 3'd2,
    S_REPEAT   = 3'd3,
    S_HOLD     = 3'd4
  } btn_state_t;

  // Debounced "button down" level is a pure function of the state entered.
  function automatic logic state_is_held(btn_state_t s);
    return (s == S_DELAY) || (s == S_REPEAT) || (s == S_HOLD);
  endfunction

endpackage

// File: rtl/btn_repeat_channel.sv
// One button channel: debounce, first-press pulse, and optional
// DAS/ARR-style auto-repeat while held. repeat_en is only looked at
// on the debounce exit edge.
module btn_repeat_channel
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE,
  parameter int unsigned DELAY    = DEF_DELAY,
  parameter int unsigned REPEAT   = DEF_REPEAT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic repeat_en,
  output logic btn_press,
  output logic btn_held
);

  // Reject timing values the counter cannot represent.
  if (DEBOUNCE == 0 || (64'(DEBOUNCE) >> CNT_W) != 64'd0) begin : g_bad_debounce
    $error("btn_repeat_channel: DEBOUNCE must be in 1 .. 2**CNT_W-1");
  end
  if (DELAY == 0 || (64'(DELAY) >> CNT_W) != 64'd0) begin : g_bad_delay
    $error("btn_repeat_channel: DELAY must be in 1 .. 2**CNT_W-1");
  end
  if (REPEAT == 0 || (64'(REPEAT) >> CNT_W) != 64'd0) begin : g_bad_repeat
    $error("btn_repeat_channel: REPEAT must be in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DL_LAST  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt;

  // State, counter and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      btn_press <= 1'b0;
      btn_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_press <= press_nxt;
      btn_held  <= state_is_held(state_nxt);
    end
  end

  // Next-state selection; any low sample outside IDLE releases the channel.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (btn) state_nxt = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!btn)                state_nxt = S_IDLE;
        else if (cnt == DB_LAST) state_nxt = repeat_en ? S_DELAY : S_HOLD;
      end
      S_DELAY: begin
        if (!btn)                state_nxt = S_IDLE;
        else if (cnt == DL_LAST) state_nxt = S_REPEAT;
      end
      S_REPEAT: begin
        if (!btn) state_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (!btn) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter update and pulse generation; counter clears on every terminal count.
  always_comb begin
    cnt_nxt   = '0;
    press_nxt = 1'b0;
    case (state)
      S_DEBOUNCE: begin
        if (btn) begin
          if (cnt == DB_LAST) press_nxt = 1'b1;
          else                cnt_nxt   = cnt + CNT_ONE;
        end
      end
      S_DELAY: begin
        if (btn) begin
          if (cnt == DL_LAST) press_nxt = 1'b1;
          else                cnt_nxt   = cnt + CNT_ONE;
        end
      end
      S_REPEAT: begin
        if (btn) begin
          if (cnt == RP_LAST) press_nxt = 1'b1;
          else                cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        press_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/btn_control_repeat_multi.sv
// N-channel button front end: one btn_repeat_channel per button.
// Optional macro BTN_SYNC_EN inserts a 2-flop synchronizer per input
// (adds exactly 2 cycles to every pulse latency).
module btn_control_repeat_multi
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned N_BTN    = DEF_N_BTN,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE,
  parameter int unsigned DELAY    = DEF_DELAY,
  parameter int unsigned REPEAT   = DEF_REPEAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_held
);

  logic [N_BTN-1:0] btn_fsm;

`ifdef BTN_SYNC_EN
  logic [N_BTN-1:0] sync_q1, sync_q2;

  // Two-stage synchronizer for the asynchronous button pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  assign btn_fsm = sync_q2;
`else
  assign btn_fsm = btn_in;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_repeat_channel #(
      .CNT_W    (CNT_W),
      .DEBOUNCE (DEBOUNCE),
      .DELAY    (DELAY),
      .REPEAT   (REPEAT)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn_fsm[i]),
      .repeat_en (repeat_en[i]),
      .btn_press (btn_press[i]),
      .btn_held  (btn_held[i])
    );
  end

endmodule

// File: tb/tb_btn_control_repeat_multi.sv
// Directed testbench for btn_control_repeat_multi with DEBOUNCE=4,
// DELAY=10, REPEAT=3. Expected values are offset by 2 cycles when
// BTN_SYNC_EN is defined.
module tb_btn_control_repeat_multi;

  localparam int N   = 4;
  localparam int TDB = 4;
  localparam int TDL = 10;
  localparam int TRP = 3;
`ifdef BTN_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] repeat_en;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_held;

  int checks   = 0;
  int failures = 0;

  btn_control_repeat_multi #(
    .N_BTN    (N),
    .CNT_W    (8),
    .DEBOUNCE (TDB),
    .DELAY    (TDL),
    .REPEAT   (TRP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .btn_press (btn_press),
    .btn_held  (btn_held)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse expected after FSM edge f when b was seen high on edges 0..last.
  function automatic logic exp_pulse(int f, bit rep, int last);
    if (f < 0 || f > last) return 1'b0;
    if (f == TDB) return 1'b1;
    if (rep && f >= TDB + TDL && ((f - TDB - TDL) % TRP) == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_held(int f, int last);
    return (f >= TDB) && (f <= last);
  endfunction

  task automatic settle();
    btn_in    = '0;
    repeat_en = '0;
    repeat (6) step();
    chk("idle_held", 32'(btn_held), 32'h0);
  endtask

  // Channel 0 held for edges 0..29, then released.
  task automatic hold_ch0(input bit rep, input string name);
    repeat_en = {3'b000, rep};
    for (int e = 0; e <= 29 + L + 3; e++) begin
      btn_in[0] = (e <= 29);
      step();
      chk($sformatf("%s_press0_e%0d", name, e), 32'(btn_press[0]), 32'(exp_pulse(e - L, rep, 29)));
      chk($sformatf("%s_held0_e%0d", name, e), 32'(btn_held[0]), 32'(exp_held(e - L, 29)));
      chk($sformatf("%s_press_oth_e%0d", name, e), 32'(btn_press[3:1]), 32'h0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    btn_in    = '0;
    repeat_en = '0;
    repeat (3) step();
    chk("reset_press", 32'(btn_press), 32'h0);
    chk("reset_held", 32'(btn_held), 32'h0);
    reset = 1'b0;
    step();
    chk("post_reset_press", 32'(btn_press), 32'h0);

    // 1: single-shot hold
    hold_ch0(1'b0, "s1");
    settle();

    // 2: auto-repeat hold (pulses at 4,14,17,...,29 plus sync offset)
    hold_ch0(1'b1, "s2");
    settle();

    // 3: glitches shorter than debounce, then a real press on channel 1
    for (int e = 0; e <= 14 + L; e++) begin
      btn_in[1] = (e <= 2) || (e >= 4 && e <= 6) || (e >= 8 && e <= 12);
      step();
      chk($sformatf("s3_press1_e%0d", e), 32'(btn_press[1]), 32'((e - L) == 12));
      chk($sformatf("s3_held1_e%0d", e), 32'(btn_held[1]), 32'((e - L) == 12));
    end
    settle();

    // 4: channels 0 and 3 together; channel 3 released at edge 8
    repeat_en = 4'b1001;
    for (int e = 0; e <= 22 + L; e++) begin
      btn_in[0] = 1'b1;
      btn_in[3] = (e < 8);
      step();
      chk($sformatf("s4_press0_e%0d", e), 32'(btn_press[0]), 32'(exp_pulse(e - L, 1'b1, 1000)));
      chk($sformatf("s4_held0_e%0d", e), 32'(btn_held[0]), 32'(exp_held(e - L, 1000)));
      chk($sformatf("s4_press3_e%0d", e), 32'(btn_press[3]), 32'(exp_pulse(e - L, 1'b1, 7)));
      chk($sformatf("s4_held3_e%0d", e), 32'(btn_held[3]), 32'(exp_held(e - L, 7)));
    end
    settle();

    // 5: reset pulse at edge 15 during a repeat hold
    repeat_en = 4'b0001;
    for (int e = 0; e <= 36; e++) begin
      btn_in[0] = 1'b1;
      reset     = (e == 15);
      step();
      if (e < 15) begin
        chk($sformatf("s5_press_e%0d", e), 32'(btn_press[0]), 32'(exp_pulse(e - L, 1'b1, 1000)));
        chk($sformatf("s5_held_e%0d", e), 32'(btn_held[0]), 32'(exp_held(e - L, 1000)));
      end else if (e == 15) begin
        chk("s5_rst_press", 32'(btn_press), 32'h0);
        chk("s5_rst_held", 32'(btn_held), 32'h0);
      end else begin
        chk($sformatf("s5_press_e%0d", e), 32'(btn_press[0]), 32'(exp_pulse(e - 16 - L, 1'b1, 1000)));
        chk($sformatf("s5_held_e%0d", e), 32'(btn_held[0]), 32'(exp_held(e - 16 - L, 1000)));
      end
    end
    reset = 1'b0;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
